// File: rtl/food_place_ctrl.sv
// food_place_ctrl: places a food item on a free playfield cell.
// A random candidate cell is drawn, checked against every snake body segment
// read back from the segment RAM, and redrawn on collision until a free cell
// is found or the retry budget runs out.
module food_place_ctrl #(
    parameter int GRID_W    = 20,
    parameter int GRID_H    = 20,
    parameter int CELL      = 25,
    parameter int OFFSET    = 2,
    parameter int MAX_LEN   = 64,
    parameter int ADDR_W    = 6,
    parameter int MAX_TRIES = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              place_req,
    input  logic [9:0]        rand_x,
    input  logic [9:0]        rand_y,
    input  logic [ADDR_W:0]   snake_len,
    output logic [ADDR_W-1:0] seg_addr,
    input  logic [9:0]        seg_x,
    input  logic [9:0]        seg_y,
    output logic [9:0]        food_x,
    output logic [9:0]        food_y,
    output logic              food_valid,
    output logic              busy,
    output logic              place_done,
    output logic              place_fail
);

    localparam int LEN_W = ADDR_W + 1;
    localparam int TRY_W = $clog2(MAX_TRIES + 2);

    localparam logic [9:0]       GRID_W_C    = 10'(GRID_W);
    localparam logic [9:0]       GRID_H_C    = 10'(GRID_H);
    localparam logic [9:0]       CELL_C      = 10'(CELL);
    localparam logic [9:0]       OFFSET_C    = 10'(OFFSET);
    localparam logic [9:0]       RESET_POS   = 10'(15 * CELL + OFFSET);
    localparam logic [LEN_W-1:0] MAX_LEN_C   = LEN_W'(MAX_LEN);
    localparam logic [TRY_W-1:0] MAX_TRIES_C = TRY_W'(MAX_TRIES);

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        SCAN,
        COMMIT,
        FAIL
    } placeState_t;

    placeState_t state;
    placeState_t stateNext;

    // Candidate cell under test
    logic [9:0]        candX;
    logic [9:0]        candY;

    // Scan address counter and the read that is in flight in the RAM
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idxNext;
    logic              pendValid;
    logic [ADDR_W-1:0] pendIdx;

    // Retry accounting
    logic [TRY_W-1:0]  tries;
    logic [TRY_W-1:0]  triesNext;
    logic [TRY_W-1:0]  triesInc;
    logic [TRY_W-1:0]  sampleTries;
    logic [TRY_W-1:0]  sampleInc;

    // Control strobes from the next-state logic
    logic              doSample;
    logic              loadCand;
    logic              issue;

    // Derived scan terms
    logic [LEN_W-1:0]  effLen;
    logic [ADDR_W-1:0] lastIdx;
    logic              randInRange;
    logic              segHit;
    logic              lastCompare;

    assign busy     = (state != IDLE);
    assign seg_addr = idx;

    // Effective length, candidate range check and compare-stage results
    always_comb begin
        effLen      = (snake_len > MAX_LEN_C) ? MAX_LEN_C : snake_len;
        lastIdx     = ADDR_W'(effLen - 1'b1);
        randInRange = (rand_x < GRID_W_C) && (rand_y < GRID_H_C);
        segHit      = pendValid && (seg_x == candX) && (seg_y == candY);
        lastCompare = pendValid && (pendIdx == lastIdx);
        triesInc    = tries + 1'b1;
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state, retry counting and scan sequencing
    always_comb begin
        stateNext   = state;
        triesNext   = tries;
        idxNext     = idx;
        issue       = 1'b0;
        doSample    = 1'b0;
        loadCand    = 1'b0;
        sampleTries = tries;
        sampleInc   = tries + 1'b1;

        case (state)
            IDLE: begin
                if (place_req) begin
                    stateNext = SAMPLE;
                    triesNext = '0;
                end
            end
            SAMPLE: begin
                doSample    = 1'b1;
                sampleTries = tries;
            end
            SCAN: begin
                if (segHit) begin
                    if (triesInc >= MAX_TRIES_C) begin
                        triesNext = triesInc;
                        stateNext = FAIL;
                    end else begin
                        // The collision edge doubles as the redraw edge, so a
                        // retry costs only the cycles spent up to the hit.
                        doSample    = 1'b1;
                        sampleTries = triesInc;
                    end
                end else if (lastCompare) begin
                    stateNext = COMMIT;
                end else begin
                    issue = 1'b1;
                    if (idx != lastIdx) begin
                        idxNext = idx + 1'b1;
                    end
                end
            end
            COMMIT: begin
                stateNext = IDLE;
            end
            FAIL: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        if (doSample) begin
            loadCand  = 1'b1;
            sampleInc = sampleTries + 1'b1;
            triesNext = sampleTries;
            if (!randInRange) begin
                triesNext = sampleInc;
                stateNext = (sampleInc >= MAX_TRIES_C) ? FAIL : SAMPLE;
            end else if (effLen == '0) begin
                stateNext = COMMIT;
            end else begin
                stateNext = SCAN;
                idxNext   = '0;
            end
        end
    end

    // Datapath: candidate latch, scan pipeline, food position and pulses
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tries      <= '0;
            idx        <= '0;
            pendValid  <= 1'b0;
            pendIdx    <= '0;
            candX      <= '0;
            candY      <= '0;
            food_x     <= RESET_POS;
            food_y     <= RESET_POS;
            food_valid <= 1'b0;
            place_done <= 1'b0;
            place_fail <= 1'b0;
        end else begin
            tries      <= triesNext;
            idx        <= idxNext;
            pendValid  <= issue;
            if (issue) begin
                pendIdx <= idx;
            end
            if (loadCand) begin
                candX <= rand_x;
                candY <= rand_y;
            end
            place_done <= (state == COMMIT);
            place_fail <= (state == FAIL);
            if (state == IDLE && place_req) begin
                food_valid <= 1'b0;
            end
            if (state == COMMIT) begin
                food_x     <= candX * CELL_C + OFFSET_C;
                food_y     <= candY * CELL_C + OFFSET_C;
                food_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_food_place_ctrl.sv
// tb_food_place_ctrl: directed table, hand-written corner sequences and
// randomized placements checked against a cell-level reference model.
module tb_food_place_ctrl;

    localparam int ADDR_W = 6;
    localparam int MAXT   = 8;
    localparam int SEQN   = 1024;
    localparam int BOUND  = 700;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              place_req;
    logic [9:0]        rand_x;
    logic [9:0]        rand_y;
    logic [ADDR_W:0]   snake_len;
    logic [ADDR_W-1:0] seg_addr;
    logic [9:0]        seg_x;
    logic [9:0]        seg_y;
    logic [9:0]        food_x;
    logic [9:0]        food_y;
    logic              food_valid;
    logic              busy;
    logic              place_done;
    logic              place_fail;

    int nChecks = 0;
    int nFails  = 0;

    logic [9:0] bodyX [64];
    logic [9:0] bodyY [64];
    logic [9:0] seqX  [SEQN];
    logic [9:0] seqY  [SEQN];

    typedef struct {
        int len;
        int x0;
        int y0;
        int x1;
        int y1;
        bit expFail;
        int expEdge;
        int expFx;
        int expFy;
    } vec_t;

    vec_t vecs [8];

    food_place_ctrl #(
        .GRID_W(20), .GRID_H(20), .CELL(25), .OFFSET(2),
        .MAX_LEN(64), .ADDR_W(ADDR_W), .MAX_TRIES(MAXT)
    ) dut (
        .clock(clock), .reset_n(reset_n), .place_req(place_req),
        .rand_x(rand_x), .rand_y(rand_y), .snake_len(snake_len),
        .seg_addr(seg_addr), .seg_x(seg_x), .seg_y(seg_y),
        .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
        .busy(busy), .place_done(place_done), .place_fail(place_fail)
    );

    always #5 clock = ~clock;

    // Synchronous-read body segment RAM
    always @(posedge clock) begin
        seg_x <= bodyX[seg_addr];
        seg_y <= bodyY[seg_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic setTableBody();
        for (int k = 0; k < 64; k++) begin
            bodyX[k] = 10'd19;
            bodyY[k] = 10'd19;
        end
        bodyX[0] = 10'd5; bodyY[0] = 10'd5;
        bodyX[1] = 10'd5; bodyY[1] = 10'd6;
        bodyX[2] = 10'd5; bodyY[2] = 10'd7;
    endtask

    // Reference: walks candidate draws per edge using the placement rules.
    // Draw edge s, candidate seq[s]; out of range costs one edge and a try;
    // a free cell commits 1 edge later when L=0, else L+2 edges later;
    // a hit at index k is seen 2+k edges after the draw and that edge redraws.
    function automatic void refModel(input int len, output bit fail, output int endEdge,
                                     output int fx, output int fy);
        int lim;
        int s;
        int tries;
        int hit;
        int x;
        int y;
        lim = (len > 64) ? 64 : len;
        s = 1;
        tries = 0;
        fail = 1'b0;
        endEdge = 0;
        fx = 0;
        fy = 0;
        while (s < SEQN) begin
            x = int'(seqX[s]);
            y = int'(seqY[s]);
            if (x >= 20 || y >= 20) begin
                tries++;
                if (tries == MAXT) begin
                    fail = 1'b1;
                    endEdge = s + 1;
                    return;
                end
                s++;
            end else begin
                hit = -1;
                for (int k = 0; k < lim; k++) begin
                    if (hit < 0 && int'(bodyX[k]) == x && int'(bodyY[k]) == y) hit = k;
                end
                if (hit < 0) begin
                    endEdge = (lim == 0) ? s + 1 : s + 2 + lim;
                    fx = x * 25 + 2;
                    fy = y * 25 + 2;
                    return;
                end
                tries++;
                if (tries == MAXT) begin
                    fail = 1'b1;
                    endEdge = s + 3 + hit;
                    return;
                end
                s = s + 2 + hit;
            end
        end
    endfunction

    // Issues one request with candidate seq[j] presented at edge T+j and
    // reports the edge index of the first done/fail pulse (0 on timeout).
    task automatic runPlacement(input int len, output bit gotDone, output bit gotFail,
                                output int edgeN, output bit busyOk);
        snake_len = (ADDR_W+1)'(len);
        place_req = 1'b1;
        rand_x = seqX[0];
        rand_y = seqY[0];
        step();
        place_req = 1'b0;
        edgeN = 0;
        gotDone = 1'b0;
        gotFail = 1'b0;
        busyOk = busy;
        for (int j = 1; j <= BOUND; j++) begin
            rand_x = seqX[j];
            rand_y = seqY[j];
            step();
            if (place_done || place_fail) begin
                gotDone = place_done;
                gotFail = place_fail;
                edgeN = j;
                break;
            end
            if (!busy) busyOk = 1'b0;
        end
    endtask

    task automatic runAndCheck(input string tag, input int len, input bit expFail,
                               input int expEdge, input int expFx, input int expFy);
        bit gd;
        bit gf;
        bit bok;
        int e;
        runPlacement(len, gd, gf, e, bok);
        check({tag, " pulse edge"}, e, expEdge);
        check({tag, " place_done"}, gd, int'(!expFail));
        check({tag, " place_fail"}, gf, int'(expFail));
        check({tag, " food_x"}, food_x, expFx);
        check({tag, " food_y"}, food_y, expFy);
        check({tag, " food_valid"}, food_valid, int'(!expFail));
        check({tag, " busy at pulse"}, busy, 0);
        check({tag, " busy while placing"}, bok, 1);
    endtask

    task automatic fillSeq(input int x0, input int y0, input int x1, input int y1);
        for (int j = 0; j < SEQN; j++) begin
            seqX[j] = 10'(x1);
            seqY[j] = 10'(y1);
        end
        seqX[1] = 10'(x0);
        seqY[1] = 10'(y0);
    endtask

    initial begin
        int modelFx;
        int modelFy;
        int pulseEdge;
        int extraPulses;
        int rLen;
        int rSpan;
        bit rFail;
        int rEdge;
        int rFx;
        int rFy;
        int expA [4];

        vecs[0] = '{0,   4,  7,  4,  7, 1'b0,  2, 102, 177};
        vecs[1] = '{3,  10,  3, 10,  3, 1'b0,  6, 252,  77};
        vecs[2] = '{3,   5,  6,  0,  0, 1'b0,  9,   2,   2};
        vecs[3] = '{3,  25,  3, 25,  3, 1'b1,  9,   2,   2};
        vecs[4] = '{100, 10, 3, 10,  3, 1'b0, 67, 252,  77};
        vecs[5] = '{1,   5,  5, 19, 19, 1'b0,  6, 477, 477};
        vecs[6] = '{3,   3, 20,  7, 19, 1'b0,  7, 177, 477};
        vecs[7] = '{2,   5,  6,  5,  5, 1'b1, 19, 177, 477};

        expA[0] = 0; expA[1] = 1; expA[2] = 2; expA[3] = 2;

        reset_n = 1'b0;
        place_req = 1'b0;
        rand_x = '0;
        rand_y = '0;
        snake_len = '0;
        setTableBody();
        fillSeq(0, 0, 0, 0);

        // Reset state and idle behaviour
        step();
        step();
        reset_n = 1'b1;
        step();
        check("reset food_x", food_x, 377);
        check("reset food_y", food_y, 377);
        check("reset food_valid", food_valid, 0);
        check("reset busy", busy, 0);
        check("reset seg_addr", seg_addr, 0);
        check("reset pulses", {place_done, place_fail}, 0);
        step();
        step();
        check("idle stays idle", busy, 0);

        // Scan address walk, requests while busy ignored, single done pulse
        snake_len = 7'd3;
        rand_x = 10'd10;
        rand_y = 10'd3;
        place_req = 1'b1;
        step();
        pulseEdge = 0;
        for (int j = 1; j <= 20; j++) begin
            place_req = (j == 2 || j == 3);
            step();
            if (j <= 4) check($sformatf("seg_addr at T+%0d", j), seg_addr, expA[j-1]);
            if (place_done && pulseEdge == 0) pulseEdge = j;
            if (pulseEdge != 0) break;
        end
        place_req = 1'b0;
        check("walk done edge", pulseEdge, 6);
        check("walk food_x", food_x, 252);
        check("walk food_y", food_y, 77);
        extraPulses = 0;
        for (int j = 0; j < 12; j++) begin
            step();
            if (place_done || place_fail || busy) extraPulses++;
        end
        check("no activity after ignored request", extraPulses, 0);

        // Directed table
        for (int i = 0; i < 8; i++) begin
            setTableBody();
            if (i == 7) begin
                bodyX[1] = 10'd5;
                bodyY[1] = 10'd6;
            end
            fillSeq(vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1);
            runAndCheck($sformatf("vec%0d", i), vecs[i].len, vecs[i].expFail,
                        vecs[i].expEdge, vecs[i].expFx, vecs[i].expFy);
            step();
        end

        // Reset in the middle of a scan
        setTableBody();
        fillSeq(10, 3, 10, 3);
        snake_len = 7'd3;
        rand_x = 10'd10;
        rand_y = 10'd3;
        place_req = 1'b1;
        step();
        place_req = 1'b1;
        step();
        step();
        step();
        check("mid-scan busy before reset", busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid-scan reset busy", busy, 0);
        check("mid-scan reset food_x", food_x, 377);
        check("mid-scan reset food_y", food_y, 377);
        check("mid-scan reset food_valid", food_valid, 0);
        check("mid-scan reset seg_addr", seg_addr, 0);
        place_req = 1'b0;
        step();
        reset_n = 1'b1;
        extraPulses = 0;
        for (int j = 0; j < 10; j++) begin
            step();
            if (place_done || place_fail || busy) extraPulses++;
        end
        check("no pulse after mid-scan reset", extraPulses, 0);
        modelFx = 377;
        modelFy = 377;

        // Randomized placements against the reference model
        for (int t = 0; t < 40; t++) begin
            rLen = ($urandom_range(0, 9) == 0) ? int'($urandom_range(65, 100))
                                                : int'($urandom_range(0, 12));
            rSpan = int'($urandom_range(4, 22));
            for (int k = 0; k < 64; k++) begin
                bodyX[k] = 10'($urandom_range(0, 4));
                bodyY[k] = 10'($urandom_range(0, 4));
            end
            for (int j = 0; j < SEQN; j++) begin
                seqX[j] = 10'($urandom_range(0, rSpan - 1));
                seqY[j] = 10'($urandom_range(0, rSpan - 1));
            end
            refModel(rLen, rFail, rEdge, rFx, rFy);
            if (!rFail) begin
                modelFx = rFx;
                modelFy = rFy;
            end
            runAndCheck($sformatf("rand%0d", t), rLen, rFail, rEdge, modelFx, modelFy);
            if ($urandom_range(0, 1) == 1) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
